// File: rtl/fetch_queue_pkg.sv
// Shared frontend types and default sizing for the fetch queue.
// Each queue entry is one instruction word tagged with its own PC.
package fetch_queue_pkg;

  localparam int FQ_IF_WIDTH = 2;
  localparam int FQ_ID_WIDTH = 2;
  localparam int FQ_DEPTH    = 16;

  localparam int FQ_OFS_W = $clog2(FQ_IF_WIDTH);
  localparam int FQ_PTR_W = $clog2(FQ_DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  // A one-lane group has no slot field; keep the slot vector at least 1 bit wide.
  function automatic int slot_width(input int ofs);
    return (ofs > 0) ? ofs : 1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-group input and decode output bundle of the fetch queue.
// The master drives fetch groups and decode ready; the slave is the queue itself.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int IF_WIDTH = FQ_IF_WIDTH,
  parameter int ID_WIDTH = FQ_ID_WIDTH
);

  logic                              prv_valid;
  logic                              prv_ready;
  logic [31:0]                       pc;
  logic [IF_WIDTH-1:0][31:0]         insts;
  logic [ID_WIDTH-1:0]               dec_valid;
  logic                              dec_ready;
  logic [ID_WIDTH-1:0][31:0]         dec_insts;
  logic [ID_WIDTH-1:0][31:0]         dec_pc;

  modport master (
    output prv_valid, pc, insts, dec_ready,
    input  prv_ready, dec_valid, dec_insts, dec_pc
  );

  modport slave (
    input  prv_valid, pc, insts, dec_ready,
    output prv_ready, dec_valid, dec_insts, dec_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode: drops lanes before the PC slot,
// stores survivors with their PCs, and presents up to ID_WIDTH oldest entries.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int IF_WIDTH = FQ_IF_WIDTH,
  parameter int ID_WIDTH = FQ_ID_WIDTH,
  parameter int DEPTH    = FQ_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  fetch_queue_if.slave bus
);

  localparam int OFS    = $clog2(IF_WIDTH);
  localparam int SLOT_W = slot_width(OFS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] IFW_C   = CNT_W'(IF_WIDTH);
  localparam logic [CNT_W-1:0] IDW_C   = CNT_W'(ID_WIDTH);

  fetch_entry_t      mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  enq_n, deq_k;
  logic [SLOT_W-1:0] slot;
  logic [31:0]       base;
  logic              ready, enq, deq;
  logic [1:0]        unused_pc_lo;

  generate
    if (OFS > 0) begin : g_slot
      assign slot = bus.pc[OFS+1:2];
    end else begin : g_noslot
      assign slot = '0;
    end
  endgenerate

  assign base         = {bus.pc[31:OFS+2], {(OFS+2){1'b0}}};
  assign unused_pc_lo = bus.pc[1:0];

  // Ready looks only at the registered count, so a full group always fits.
  assign ready         = (DEPTH_C - count) >= IFW_C;
  assign bus.prv_ready = ready;

  assign enq   = bus.prv_valid && ready && !flush;
  assign deq   = bus.dec_ready && !flush;
  assign enq_n = IFW_C - CNT_W'(slot);
  assign deq_k = (count > IDW_C) ? IDW_C : count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + enq_n[PTR_W-1:0];
      if (deq) rd_ptr <= rd_ptr + deq_k[PTR_W-1:0];
      count <= count + (enq ? enq_n : '0) - (deq ? deq_k : '0);
    end
  end

  // Lane i lands at wr_ptr + (i - slot); pointer truncation wraps each entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IF_WIDTH; i++) begin
      if (enq && (SLOT_W'(i) >= slot)) begin
        mem[wr_ptr + PTR_W'(i) - PTR_W'(slot)] <= '{inst: bus.insts[i],
                                                    pc:   base + 32'(4 * i)};
      end
    end
  end

  generate
    for (genvar j = 0; j < ID_WIDTH; j++) begin : g_dec
      fetch_entry_t e;
      assign e                = mem[rd_ptr + PTR_W'(j)];
      assign bus.dec_valid[j] = count > CNT_W'(j);
      assign bus.dec_insts[j] = e.inst;
      assign bus.dec_pc[j]    = e.pc;
    end
  endgenerate

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int IFW   = 2;
  localparam int IDW   = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fetch_entry_t mq[$];

  fetch_queue_if #(.IF_WIDTH(IFW), .ID_WIDTH(IDW)) bus();

  fetch_queue #(.IF_WIDTH(IFW), .ID_WIDTH(IDW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        rdy;
    logic        fl;
    logic [1:0]  e_valid;
    int          e_cnt;
    logic        e_prdy;
    logic [31:0] e_inst0;
    logic [31:0] e_pc0;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] i0,
                       input logic [31:0] i1, input logic rdy, input logic fl);
    bus.prv_valid = v;
    bus.pc        = p;
    bus.insts[0]  = i0;
    bus.insts[1]  = i1;
    bus.dec_ready = rdy;
    flush         = fl;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // One clock: the model applies the rules to the inputs present at the edge.
  task automatic cycle();
    bit          enq;
    int          k;
    int          s;
    logic [31:0] b;
    enq = bus.prv_valid && ((DEPTH - mq.size()) >= IFW) && !flush;
    k   = (mq.size() < IDW) ? mq.size() : IDW;
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (bus.dec_ready) repeat (k) void'(mq.pop_front());
      if (enq) begin
        s = int'(bus.pc >> 2) % IFW;
        b = bus.pc & ~32'(IFW * 4 - 1);
        for (int i = s; i < IFW; i++) mq.push_back('{inst: bus.insts[i], pc: b + 32'(4 * i)});
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    for (int j = 0; j < IDW; j++)
      chk($sformatf("%s.valid%0d", tag, j), 64'(bus.dec_valid[j]), 64'(j < n));
    chk($sformatf("%s.prv_ready", tag), 64'(bus.prv_ready), 64'((DEPTH - n) >= IFW));
    chk($sformatf("%s.count", tag), 64'(dut.count), 64'(n));
    for (int j = 0; j < IDW && j < n; j++) begin
      chk($sformatf("%s.inst%0d", tag, j), 64'(bus.dec_insts[j]), 64'(mq[j].inst));
      chk($sformatf("%s.pc%0d", tag, j), 64'(bus.dec_pc[j]), 64'(mq[j].pc));
    end
  endtask

  task automatic reset_dut();
    idle();
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset_dut();
    chk("reset.dec_valid", 64'(bus.dec_valid), 64'h0);
    chk("reset.prv_ready", 64'(bus.prv_ready), 64'h1);
    chk("reset.count", 64'(dut.count), 64'h0);

    // v, pc, i0, i1, rdy, fl | valid, count, prv_ready, inst0, pc0
    tv[0] = '{1'b1, 32'h1000, 32'hAAAA0001, 32'hBBBB0002, 1'b0, 1'b0, 2'b11, 2, 1'b1, 32'hAAAA0001, 32'h1000};
    tv[1] = '{1'b1, 32'h1004, 32'hCCCC0003, 32'hDDDD0004, 1'b0, 1'b0, 2'b11, 3, 1'b1, 32'hAAAA0001, 32'h1000};
    tv[2] = '{1'b0, 32'h0,    32'h0,        32'h0,        1'b1, 1'b0, 2'b01, 1, 1'b1, 32'hDDDD0004, 32'h1004};
    tv[3] = '{1'b0, 32'h0,    32'h0,        32'h0,        1'b0, 1'b1, 2'b00, 0, 1'b1, 32'h0,        32'h0};
    tv[4] = '{1'b1, 32'h1004, 32'hCCCC0003, 32'hDDDD0004, 1'b0, 1'b0, 2'b01, 1, 1'b1, 32'hDDDD0004, 32'h1004};
    tv[5] = '{1'b1, 32'h2008, 32'hEEEE0005, 32'hFFFF0006, 1'b1, 1'b0, 2'b11, 2, 1'b1, 32'hEEEE0005, 32'h2008};
    tv[6] = '{1'b1, 32'h200C, 32'h12340007, 32'h56780008, 1'b1, 1'b0, 2'b01, 1, 1'b1, 32'h56780008, 32'h200C};
    tv[7] = '{1'b0, 32'h0,    32'h0,        32'h0,        1'b1, 1'b0, 2'b00, 0, 1'b1, 32'h0,        32'h0};
    tv[8] = '{1'b0, 32'h0,    32'h0,        32'h0,        1'b1, 1'b0, 2'b00, 0, 1'b1, 32'h0,        32'h0};

    for (int t = 0; t < 9; t++) begin
      drive(tv[t].v, tv[t].pc, tv[t].i0, tv[t].i1, tv[t].rdy, tv[t].fl);
      cycle();
      chk($sformatf("vec%0d.dec_valid", t), 64'(bus.dec_valid), 64'(tv[t].e_valid));
      chk($sformatf("vec%0d.count", t), 64'(dut.count), 64'(tv[t].e_cnt));
      chk($sformatf("vec%0d.prv_ready", t), 64'(bus.prv_ready), 64'(tv[t].e_prdy));
      if (tv[t].e_valid[0]) begin
        chk($sformatf("vec%0d.inst0", t), 64'(bus.dec_insts[0]), 64'(tv[t].e_inst0));
        chk($sformatf("vec%0d.pc0", t), 64'(bus.dec_pc[0]), 64'(tv[t].e_pc0));
      end
    end

    // Fill to the brim, try a 9th group, then free one decode window.
    reset_dut();
    for (int g = 0; g < 8; g++) begin
      drive(1'b1, 32'h4000 + 32'(8 * g), 32'h40000000 + 32'(2 * g), 32'h40000001 + 32'(2 * g), 1'b0, 1'b0);
      cycle();
      check_model($sformatf("fill%0d", g));
    end
    chk("full.prv_ready", 64'(bus.prv_ready), 64'h0);
    chk("full.count", 64'(dut.count), 64'd16);
    drive(1'b1, 32'h5000, 32'hDEAD0000, 32'hBEEF0000, 1'b0, 1'b0);
    cycle();
    chk("full.blocked_count", 64'(dut.count), 64'd16);
    check_model("full.blocked");
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("full.drain_count", 64'(dut.count), 64'd14);
    chk("full.drain_ready", 64'(bus.prv_ready), 64'h1);
    chk("full.drain_pc0", 64'(bus.dec_pc[0]), 64'h4008);
    check_model("full.drain");

    // Walk both pointers to 15, then a group that straddles 15 -> 0.
    reset_dut();
    for (int g = 0; g < 7; g++) begin
      drive(1'b1, 32'h6000 + 32'(8 * g), 32'h60000000 + 32'(g), 32'h61000000 + 32'(g), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 32'h6104, 32'h0, 32'h62000000, 1'b0, 1'b0);
    cycle();
    check_model("wrap.prime");
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (8) cycle();
    chk("wrap.empty_count", 64'(dut.count), 64'h0);
    chk("wrap.rd_ptr", 64'(dut.rd_ptr), 64'd15);
    drive(1'b1, 32'h3000, 32'hC0C0C0C0, 32'hD0D0D0D0, 1'b0, 1'b0);
    cycle();
    chk("wrap.dec_valid", 64'(bus.dec_valid), 64'h3);
    chk("wrap.inst0", 64'(bus.dec_insts[0]), 64'hC0C0C0C0);
    chk("wrap.inst1", 64'(bus.dec_insts[1]), 64'hD0D0D0D0);
    chk("wrap.pc0", 64'(bus.dec_pc[0]), 64'h3000);
    chk("wrap.pc1", 64'(bus.dec_pc[1]), 64'h3004);

    // Flush wins over a concurrent enqueue and dequeue.
    reset_dut();
    drive(1'b1, 32'h7000, 32'h70000000, 32'h70000001, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h7008, 32'h70000002, 32'h70000003, 1'b0, 1'b0);
    cycle();
    chk("flush.pre_count", 64'(dut.count), 64'd4);
    drive(1'b1, 32'h7010, 32'h70000004, 32'h70000005, 1'b1, 1'b1);
    cycle();
    chk("flush.count", 64'(dut.count), 64'h0);
    chk("flush.dec_valid", 64'(bus.dec_valid), 64'h0);
    chk("flush.prv_ready", 64'(bus.prv_ready), 64'h1);
    drive(1'b1, 32'h2000, 32'h20000000, 32'h20000001, 1'b0, 1'b0);
    cycle();
    chk("flush.after_pc0", 64'(bus.dec_pc[0]), 64'h2000);
    chk("flush.after_inst0", 64'(bus.dec_insts[0]), 64'h20000000);
    check_model("flush.after");

    // Reset asserted between clock edges clears visibly without a clock.
    reset_dut();
    for (int g = 0; g < 3; g++) begin
      drive(1'b1, 32'h8000 + 32'(8 * g), 32'h80000000 + 32'(g), 32'h81000000 + 32'(g), 1'b0, 1'b0);
      cycle();
    end
    chk("areset.pre_count", 64'(dut.count), 64'd6);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("areset.dec_valid", 64'(bus.dec_valid), 64'h0);
    chk("areset.prv_ready", 64'(bus.prv_ready), 64'h1);
    chk("areset.count", 64'(dut.count), 64'h0);
    mq.delete();
    #1;
    rst = 1'b0;
    drive(1'b1, 32'h9000, 32'h90000000, 32'h90000001, 1'b0, 1'b0);
    cycle();
    chk("areset.after_valid", 64'(bus.dec_valid), 64'h3);
    chk("areset.after_pc0", 64'(bus.dec_pc[0]), 64'h9000);
    check_model("areset.after");

    // Random traffic against the reference queue.
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0,
            32'h10000 + (32'($urandom_range(0, 1023)) << 2),
            $urandom(), $urandom(),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 24) == 0);
      cycle();
      check_model($sformatf("rnd%0d", c));
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer directly downstream of the first fetch stage.
- Accepts one fetch group per cycle (a PC plus IF_WIDTH instruction words) and drops the lanes that precede the PC's slot within the aligned group.
- Stores surviving instructions with their individual PCs in a circular FIFO.
- Presents up to ID_WIDTH oldest entries per cycle to decode; flush empties it in one cycle.

Parameters:
- IF_WIDTH, 2: instruction words per fetch group; power of two.
- ID_WIDTH, 2: max instructions handed to decode per cycle.
- DEPTH, 16: queue entries; power of two, at least 2*max(IF_WIDTH,ID_WIDTH).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- flush  input  1  discard all queued and incoming instructions
- prv_valid  input  1  fetch group valid
- prv_ready  output  1  queue can accept a full group
- pc  input  32  PC of first useful instruction in group
- insts  input  IF_WIDTH x 32  group words, lane 0 at aligned group base
- dec_valid  output  ID_WIDTH  per-lane valid, contiguous from lane 0
- dec_ready  input  1  decode consumes all asserted dec_valid lanes this cycle
- dec_insts  output  ID_WIDTH x 32  instructions, lane 0 oldest
- dec_pc  output  ID_WIDTH x 32  PC of each lane

Behaviour:
- Constants: OFS = clog2(IF_WIDTH). Slot s = pc[OFS+1:2]. Group base = {pc[31:OFS+2], zeros}. Lane i PC = base + 4*i.
- Enqueue fires when prv_valid && prv_ready && !flush.
  - Writes lanes s..IF_WIDTH-1 in ascending order into consecutive entries starting at the write pointer.
  - Enqueue count n = IF_WIDTH - s, range 1..IF_WIDTH.
- prv_ready = (DEPTH - count) >= IF_WIDTH.
  - Uses registered count only; no same-cycle dequeue credit. It is independent of flush.
  - A handshake in a flush cycle completes, and its data is discarded.
- Dequeue: k = popcount(dec_valid) = min(count, ID_WIDTH).
  - dec_valid lane j = (j < count).
  - dec_insts[j] and dec_pc[j] come from entry rd_ptr+j modulo DEPTH.
  - When dec_ready && !flush, rd_ptr advances by k.
  - dec_ready with k=0 has no effect.
- Outputs are combinational from registered storage and pointers. There is no bypass: an enqueued instruction becomes visible on dec_* the cycle after the write.
- Simultaneous enqueue and dequeue: both apply. count_next = count + n - k, never exceeds DEPTH, guaranteed by the prv_ready rule.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count is clog2(DEPTH)+1 bits. A group or dequeue window straddling index DEPTH-1 -> 0 must wrap per entry.
- Flush: next cycle rd_ptr = wr_ptr = 0 and count = 0. Concurrent enqueue and dequeue are both suppressed, so dec_valid = 0 the cycle after flush.
- Reset (asynchronous, any time including mid-transfer):
  - rd_ptr = wr_ptr = 0, count = 0, dec_valid = 0.
  - prv_ready = 1 (since DEPTH >= IF_WIDTH).
  - Storage array is not reset. dec_insts and dec_pc are don't-care while dec_valid = 0.
- dec_insts and dec_pc on invalid lanes are don't-care. The bench must not check them.

Decomposition:
- Shared frontend package holds:
  - fetch_entry_t struct: inst[31:0], pc[31:0].
  - Localparams for slot offset width and pointer width derived from IF_WIDTH and DEPTH.
- Storage is a plain register array of fetch_entry_t inside the module.
- No sub-module is needed: the alignment/compaction logic and pointer arithmetic are small enough to live inline.

Test Plan:
- Aligned fill: IF_WIDTH=2, dec_ready=0, group pc=0x1000, insts {A,B}.
  - Cycle after: dec_valid=2'b11, dec_insts {A,B}, dec_pc {0x1000,0x1004}, count=2.
- Misaligned entry: pc=0x1004, insts {X,Y}.
  - Only Y is queued: dec_valid=2'b01, dec_pc[0]=0x1004, count=1.
- Full/backpressure: dec_ready=0, push 8 aligned groups into DEPTH=16.
  - prv_ready drops to 0 after the 8th. A 9th prv_valid is not accepted. count stays 16.
  - Then dec_ready=1 for 1 cycle: count=14, and prv_ready=1 the next cycle.
- Wrap-around: prime rd_ptr = wr_ptr = 15, enqueue aligned group {C,D}.
  - C lands in entry 15, D in entry 0. dec_insts {C,D} in order.
- Simultaneous push/pop with flush: count=4, dec_ready=1, enqueue group, flush=1 in the same cycle.
  - Next cycle count=0, dec_valid=0, prv_ready=1.
  - The following group pc=0x2000 appears with dec_pc[0]=0x2000.
- Async reset: assert rst mid-cycle with count=6 and no clock edge.
  - dec_valid goes to 0 immediately. After release, the first enqueued group is visible the next cycle.
